// File: rtl/branch_resolve_bht_pkg.sv
// Shared widths, branch funct3 encodings and BHT counter helpers for branch_resolve_bht.
package branch_resolve_bht_pkg;

  localparam int unsigned BITS = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_ctr_t;

  // funct3 010/011 are the only undefined branch encodings
  function automatic logic br_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic lt, input logic ltu,
                                    input logic eq);
    logic tk;
    unique case (f3)
      F3_BEQ:  tk = eq;
      F3_BNE:  tk = ~eq;
      F3_BLT:  tk = lt;
      F3_BGE:  tk = ~lt;
      F3_BLTU: tk = ltu;
      F3_BGEU: tk = ~ltu;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t n;
    n = c;
    if (taken && c != ST) begin
      n = bht_ctr_t'(c + 2'd1);
    end else if (!taken && c != SNT) begin
      n = bht_ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_bht_table.sv
// Branch history table: 2-bit saturating counters, combinational read, one write per cycle.
module bht_table
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned Entries = 64,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic            rd_msb_o,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic            wr_taken_i
);

  bht_ctr_t ctr_q [Entries];
  bht_ctr_t ctr_d [Entries];

  // Read sees the pre-update value when read and write hit the same entry.
  assign rd_msb_o = ctr_q[rd_idx_i][1];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en_i) begin
      ctr_d[wr_idx_i] = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        ctr_q[i] <= WNT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// Execute-stage branch resolution, mispredict flush/redirect and BHT ownership.
// Optional BRANCH_STATS_EN adds BR_COUNT / MISPRED_COUNT outputs.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] IF_PC,
  output logic            IF_PRED_TAKEN,
  input  logic            EX_VALID,
  input  logic            EX_BRANCH,
  input  logic            EX_STALL,
  input  logic [2:0]      EX_FUNCT3,
  input  logic            LT,
  input  logic            LTU,
  input  logic            EQ,
  input  logic            EX_PRED_TAKEN,
  input  logic [BITS-1:0] EX_PC,
  input  logic [BITS-1:0] EX_TARGET,
  output logic            FLUSH,
  output logic [BITS-1:0] REDIRECT_PC,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISPRED_COUNT,
`endif
  output logic            ILLEGAL_BR
);

  logic            flush_q, flush_d;
  logic [BITS-1:0] redirect_q, redirect_d;
  logic            illegal_q, illegal_d;

  logic resolve, legal, taken, mispredict;

  logic unused_if_pc;
  assign unused_if_pc = ^{IF_PC[BITS-1:BHT_IDX_W+2], IF_PC[1:0]};

  // The !flush_q term squashes the wrong-path instruction sitting in EX after a flush.
  assign resolve    = EX_VALID & EX_BRANCH & ~EX_STALL & ~flush_q;
  assign legal      = br_legal(EX_FUNCT3);
  assign taken      = legal & br_taken(EX_FUNCT3, LT, LTU, EQ);
  assign mispredict = resolve & legal & (taken != EX_PRED_TAKEN);

  always_comb begin
    flush_d    = mispredict;
    illegal_d  = resolve & ~legal;
    redirect_d = redirect_q;
    if (mispredict) begin
      redirect_d = taken ? EX_TARGET : EX_PC + BITS'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
    end
  end

  assign FLUSH       = flush_q;
  assign REDIRECT_PC = redirect_q;
  assign ILLEGAL_BR  = illegal_q;

  bht_table #(
    .Entries (BHT_ENTRIES),
    .IdxW    (BHT_IDX_W)
  ) u_bht_table (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (IF_PC[BHT_IDX_W+1:2]),
    .rd_msb_o   (IF_PRED_TAKEN),
    .wr_en_i    (resolve & legal),
    .wr_idx_i   (EX_PC[BHT_IDX_W+1:2]),
    .wr_taken_i (taken)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (resolve && legal) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (mispredict) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign BR_COUNT      = br_count_q;
  assign MISPRED_COUNT = mispred_count_q;
`endif

endmodule
